// File: rtl/ifence_sequencer.sv
// FENCE.I sequencer: stalls the pipeline, flushes the D$, invalidates the I$,
// then redirects fetch to the instruction after the fence.
module ifence_sequencer #(
  parameter int unsigned TIMEOUT     = 1024,
  parameter bit          SKIP_DCACHE = 1'b0
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ifence,
  input  logic        ex_valid,
  input  logic [31:0] pc_ex,
  output logic        dcache_flush,
  input  logic        dcache_flush_done,
  output logic        icache_clear,
  input  logic        icache_clear_done,
  output logic        stall,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic        fence_fault,
  output logic        fence_err
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DFLUSH   = 2'd1,
    ICLEAR   = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          trigger;
  logic          phase_last;

  assign trigger    = (state == IDLE) & ifence & ex_valid;
  assign phase_last = (cnt == LAST);

  // Combinational so the fence itself is held in its trigger cycle.
  assign stall = (state == DFLUSH) | (state == ICLEAR) | trigger;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state        <= IDLE;
      cnt          <= '0;
      dcache_flush <= 1'b0;
      icache_clear <= 1'b0;
      redirect     <= 1'b0;
      busy         <= 1'b0;
      fence_fault  <= 1'b0;
      fence_err    <= 1'b0;
      redirect_pc  <= '0;
    end else begin
      redirect    <= 1'b0;
      fence_fault <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            redirect_pc <= pc_ex + 32'd4;
            cnt         <= '0;
            busy        <= 1'b1;
            if (SKIP_DCACHE) begin
              state        <= ICLEAR;
              icache_clear <= 1'b1;
            end else begin
              state        <= DFLUSH;
              dcache_flush <= 1'b1;
            end
          end
        end
        DFLUSH: begin
          // A done arriving on the last counted cycle still wins over the timeout.
          if (dcache_flush_done) begin
            state        <= ICLEAR;
            dcache_flush <= 1'b0;
            icache_clear <= 1'b1;
            cnt          <= '0;
          end else if (phase_last) begin
            state        <= REDIRECT;
            dcache_flush <= 1'b0;
            redirect     <= 1'b1;
            fence_fault  <= 1'b1;
            fence_err    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        ICLEAR: begin
          if (icache_clear_done) begin
            state        <= REDIRECT;
            icache_clear <= 1'b0;
            redirect     <= 1'b1;
          end else if (phase_last) begin
            state        <= REDIRECT;
            icache_clear <= 1'b0;
            redirect     <= 1'b1;
            fence_fault  <= 1'b1;
            fence_err    <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        REDIRECT: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          busy         <= 1'b0;
          dcache_flush <= 1'b0;
          icache_clear <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ifence_sequencer.sv
// Bench for ifence_sequencer: two instances (full flow with TIMEOUT=4, D$ skipped with TIMEOUT=5).
module tb_ifence_sequencer;

  localparam int T0 = 4;
  localparam int T1 = 5;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nrst_v[2];
  logic        ifence_v[2];
  logic        ex_valid_v[2];
  logic [31:0] pc_v[2];
  logic        dd_v[2];
  logic        id_v[2];
  logic        df_o[2];
  logic        ic_o[2];
  logic        st_o[2];
  logic        rd_o[2];
  logic [31:0] rpc_o[2];
  logic        bz_o[2];
  logic        ff_o[2];
  logic        fe_o[2];

  ifence_sequencer #(.TIMEOUT(T0), .SKIP_DCACHE(1'b0)) dut0 (
    .CLK(CLK), .nRST(nrst_v[0]), .ifence(ifence_v[0]), .ex_valid(ex_valid_v[0]),
    .pc_ex(pc_v[0]), .dcache_flush(df_o[0]), .dcache_flush_done(dd_v[0]),
    .icache_clear(ic_o[0]), .icache_clear_done(id_v[0]), .stall(st_o[0]),
    .redirect(rd_o[0]), .redirect_pc(rpc_o[0]), .busy(bz_o[0]),
    .fence_fault(ff_o[0]), .fence_err(fe_o[0])
  );

  ifence_sequencer #(.TIMEOUT(T1), .SKIP_DCACHE(1'b1)) dut1 (
    .CLK(CLK), .nRST(nrst_v[1]), .ifence(ifence_v[1]), .ex_valid(ex_valid_v[1]),
    .pc_ex(pc_v[1]), .dcache_flush(df_o[1]), .dcache_flush_done(dd_v[1]),
    .icache_clear(ic_o[1]), .icache_clear_done(id_v[1]), .stall(st_o[1]),
    .redirect(rd_o[1]), .redirect_pc(rpc_o[1]), .busy(bz_o[1]),
    .fence_fault(ff_o[1]), .fence_err(fe_o[1])
  );

  int   checks = 0;
  int   failures = 0;
  logic exp_err[2];

  typedef struct {
    int          inst;
    logic [31:0] pc;
    int          dk;
    int          ik;
    int          exp_r;
    logic [31:0] exp_rpc;
    logic        exp_fault;
    int          gap;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s inst%0d t=%0t actual=%h expected=%h", name, inst, $time, act, exp);
    end
  endtask

  task automatic zero_inputs(input int i);
    ifence_v[i] = 1'b0; ex_valid_v[i] = 1'b0; pc_v[i] = '0; dd_v[i] = 1'b0; id_v[i] = 1'b0;
  endtask

  task automatic check_idle(input int i, input string tag);
    chk({tag, "_stall"}, i, st_o[i], 0);
    chk({tag, "_busy"}, i, bz_o[i], 0);
    chk({tag, "_dflush"}, i, df_o[i], 0);
    chk({tag, "_iclear"}, i, ic_o[i], 0);
    chk({tag, "_redirect"}, i, rd_o[i], 0);
    chk({tag, "_fault"}, i, ff_o[i], 0);
    chk({tag, "_err"}, i, fe_o[i], exp_err[i]);
  endtask

  // Idle cycles: no valid instruction, stray ifence and done pulses must do nothing.
  task automatic idle(input int i, input int n);
    for (int k = 0; k < n; k++) begin
      ifence_v[i]   = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      ex_valid_v[i] = 1'b0;
      pc_v[i]       = $urandom;
      dd_v[i]       = 1'($urandom_range(0, 1));
      id_v[i]       = 1'($urandom_range(0, 1));
      @(negedge CLK);
      check_idle(i, "idle");
      @(posedge CLK); #1;
    end
    zero_inputs(i);
  endtask

  // dk/ik: phase cycle (1-based) on which done pulses; outside 1..TIMEOUT means never.
  task automatic run_fence(input int i, input logic [31:0] pc, input int dk, input int ik,
                           output int r_seen, output logic [31:0] rpc_seen, output logic fault_seen);
    int T, dlen, ilen, R;
    bit dfault, ifault, fault;
    T = (i == 0) ? T0 : T1;
    if (i == 1) begin
      dlen = 0; dfault = 0;
    end else begin
      dfault = !(dk >= 1 && dk <= T);
      dlen   = dfault ? T : dk;
    end
    if (dfault) begin
      ilen = 0; ifault = 0;
    end else begin
      ifault = !(ik >= 1 && ik <= T);
      ilen   = ifault ? T : ik;
    end
    fault = dfault | ifault;
    R = 1 + dlen + ilen;
    r_seen = -1; rpc_seen = '0; fault_seen = 1'b0;
    for (int c = 0; c <= R; c++) begin
      if (c == 0) begin
        ifence_v[i] = 1'b1; ex_valid_v[i] = 1'b1; pc_v[i] = pc;
      end else begin
        ifence_v[i]   = 1'($urandom_range(0, 1));
        ex_valid_v[i] = 1'($urandom_range(0, 1));
        pc_v[i]       = $urandom;
      end
      dd_v[i] = (c >= 1 && c <= dlen) ? 1'(c == dk) : 1'($urandom_range(0, 1));
      id_v[i] = (c > dlen && c <= dlen + ilen) ? 1'(c == dlen + ik) : 1'($urandom_range(0, 1));
      @(negedge CLK);
      chk("dcache_flush", i, df_o[i], 32'(c >= 1 && c <= dlen));
      chk("icache_clear", i, ic_o[i], 32'(c > dlen && c <= dlen + ilen));
      chk("stall", i, st_o[i], 32'(c <= dlen + ilen));
      chk("redirect", i, rd_o[i], 32'(c == R));
      chk("busy", i, bz_o[i], 32'(c >= 1));
      chk("fence_fault", i, ff_o[i], 32'(fault && c == R));
      if (c >= 1) chk("redirect_pc", i, rpc_o[i], pc + 32'd4);
      if (c != R) chk("fence_err", i, fe_o[i], exp_err[i]);
      if (rd_o[i] && r_seen < 0) begin
        r_seen = c; rpc_seen = rpc_o[i];
      end
      if (c == R) fault_seen = ff_o[i];
      @(posedge CLK); #1;
    end
    if (fault) exp_err[i] = 1'b1;
    zero_inputs(i);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 2; i++) begin
      nrst_v[i] = 1'b0; zero_inputs(i); exp_err[i] = 1'b0;
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    for (int i = 0; i < 2; i++) begin
      check_idle(i, "reset");
      chk("reset_rpc", i, rpc_o[i], 32'h0);
    end
    @(posedge CLK); #1;
    nrst_v[0] = 1'b1; nrst_v[1] = 1'b1;
  endtask

  initial begin
    int          r;
    logic [31:0] rpc;
    logic        flt;
    int          inst, dk, ik, T;

    tbl[0] = '{0, 32'h0000_0100, 3, 1, 5, 32'h0000_0104, 1'b0, 2};
    tbl[1] = '{1, 32'hFFFF_FFFC, 0, 1, 2, 32'h0000_0000, 1'b0, 2};
    tbl[2] = '{0, 32'h0000_0200, 0, 1, 5, 32'h0000_0204, 1'b1, 2};
    tbl[3] = '{0, 32'h0000_0300, 4, 2, 7, 32'h0000_0304, 1'b0, 0};
    tbl[4] = '{0, 32'h0000_0400, 1, 1, 3, 32'h0000_0404, 1'b0, 0};
    tbl[5] = '{0, 32'h0000_0500, 2, 9, 7, 32'h0000_0504, 1'b1, 1};
    tbl[6] = '{1, 32'h1234_5678, 0, 9, 6, 32'h1234_567C, 1'b1, 0};
    tbl[7] = '{1, 32'h0000_0800, 0, 5, 6, 32'h0000_0804, 1'b0, 1};
    tbl[8] = '{0, 32'h8000_0000, 1, 4, 6, 32'h8000_0004, 1'b0, 1};

    do_reset();
    idle(0, 4);
    idle(1, 4);

    foreach (tbl[n]) begin
      run_fence(tbl[n].inst, tbl[n].pc, tbl[n].dk, tbl[n].ik, r, rpc, flt);
      chk("tbl_redirect_cycle", tbl[n].inst, r, tbl[n].exp_r);
      chk("tbl_redirect_pc", tbl[n].inst, rpc, tbl[n].exp_rpc);
      chk("tbl_fault", tbl[n].inst, flt, tbl[n].exp_fault);
      if (tbl[n].gap > 0) idle(tbl[n].inst, tbl[n].gap);
    end

    for (int n = 0; n < 40; n++) begin
      inst = $urandom_range(0, 1);
      T    = (inst == 0) ? T0 : T1;
      dk   = $urandom_range(0, T + 1);
      ik   = $urandom_range(0, T + 1);
      run_fence(inst, $urandom, dk, ik, r, rpc, flt);
      if ($urandom_range(0, 2) != 0) idle(inst, $urandom_range(1, 2));
    end

    // Reset while the I$ clear is outstanding: everything returns to reset values.
    ifence_v[0] = 1'b1; ex_valid_v[0] = 1'b1; pc_v[0] = 32'h0000_0A00;
    @(posedge CLK); #1;
    ifence_v[0] = 1'b0; ex_valid_v[0] = 1'b0; dd_v[0] = 1'b1;
    @(posedge CLK); #1;
    dd_v[0] = 1'b0; ifence_v[0] = 1'b1; ex_valid_v[0] = 1'b1;
    @(negedge CLK);
    chk("midrst_iclear_before", 0, ic_o[0], 1);
    chk("midrst_err_before", 0, fe_o[0], exp_err[0]);
    nrst_v[0] = 1'b0; ifence_v[0] = 1'b0; ex_valid_v[0] = 1'b0;
    @(posedge CLK); #1;
    exp_err[0] = 1'b0;
    @(negedge CLK);
    check_idle(0, "midrst");
    chk("midrst_rpc", 0, rpc_o[0], 32'h0);
    nrst_v[0] = 1'b1;
    @(posedge CLK); #1;
    idle(0, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifence_sequencer.md
# ifence_sequencer

Sequences a FENCE.I instruction through the memory hierarchy for the two-stage pipeline. When the control unit decodes `ifence` on a valid execute-stage instruction, the block stalls the pipeline, has the data cache write back dirty lines, has the instruction cache invalidate, then redirects fetch to the instruction after the fence. It sits between the control unit's decode outputs, the hazard/stall logic, and the cache flush ports. A per-phase timeout guarantees forward progress.

## Interface
- `TIMEOUT`, 1024: maximum cycles spent waiting in one cache phase; legal range 2..65535.
- `SKIP_DCACHE`, 0: when 1, the data-cache flush phase is skipped (write-through or no D$ configurations).
- `CLK`  in  1  clock; all state changes on the rising edge.
- `nRST`  in  1  reset, synchronous and active-low.
- `ifence`  in  1  fence.i decoded in execute (control unit output).
- `ex_valid`  in  1  execute-stage instruction is valid (not squashed).
- `pc_ex`  in  32  PC of the execute-stage instruction.
- `dcache_flush`  out  1  request D$ write-back; level signal.
- `dcache_flush_done`  in  1  D$ write-back complete; single-cycle pulse.
- `icache_clear`  out  1  request I$ invalidate; level signal.
- `icache_clear_done`  in  1  I$ invalidate complete; single-cycle pulse.
- `stall`  out  1  hold fetch and execute.
- `redirect`  out  1  flush fetch and load `redirect_pc`; single-cycle pulse.
- `redirect_pc`  out  32  fetch target.
- `busy`  out  1  sequence in progress (state != IDLE).
- `fence_fault`  out  1  one-cycle pulse when a phase times out.
- `fence_err`  out  1  sticky timeout flag; cleared only by reset.

## Operation
- The FSM has four states: IDLE, DFLUSH, ICLEAR, REDIRECT.
- Trigger is `ifence & ex_valid` in IDLE.
  - On trigger, capture `pc_ex + 4` into `redirect_pc`. The addition is mod 2^32: 0xFFFFFFFC yields 0x00000000.
  - Next state is DFLUSH, or ICLEAR if `SKIP_DCACHE`=1.
- DFLUSH: `dcache_flush`=1.
  - `dcache_flush_done`=1 → ICLEAR.
  - Timeout → REDIRECT with fault.
- ICLEAR: `icache_clear`=1.
  - `icache_clear_done`=1 → REDIRECT.
  - Timeout → REDIRECT with fault.
- REDIRECT: `redirect`=1 and `stall`=0 for one cycle, so the fence retires. Next state is always IDLE.
  - The redirect squashes fetch, so execute holds a bubble on the following cycle and the trigger cannot re-fire.
- Timeout counter:
  - Width is clog2(TIMEOUT+1) bits; cleared on entry to DFLUSH and ICLEAR, incremented each cycle in those states.
  - Timeout means done is low while count == TIMEOUT-1, i.e. the TIMEOUT-th cycle of the phase.
  - Done in the same cycle as timeout wins: normal transition, no fault.
  - On timeout, the remaining phases are abandoned and `fence_fault` pulses in the REDIRECT cycle. `fence_err` sets on that edge and stays set.
- Done pulses outside their matching state are ignored; they are not remembered.
- Request outputs are Moore (decoded from registered state). `redirect_pc` is registered.
- `stall` = (state ∈ {DFLUSH, ICLEAR}) | (state==IDLE & `ifence` & `ex_valid`). This is combinational so the fence is held in its trigger cycle.
- `ifence` is ignored while `busy`.

## Timing
- Reset (first edge with `nRST`=0): state IDLE, counter 0. `dcache_flush`, `icache_clear`, `redirect`, `busy`, `fence_fault`, `fence_err` = 0; `redirect_pc` = 0.
  - Reset mid-sequence drops requests at that edge; no redirect is issued.
  - `stall` follows its equation combinationally.
- Cycle 0 is the trigger cycle: `stall`=1.
- The request is high from cycle 1.
- Done seen in cycle n advances the state at edge n+1.
- Minimum latency, with done in the first cycle of each phase:
  - Redirect in cycle 3 (cycle 2 when `SKIP_DCACHE`=1).
  - Total stall is 3 cycles (2 when skipped).
- Each request stays high until the edge after its done, or until timeout; it never reasserts within one sequence.
- Back-to-back fences: a new trigger is accepted in the first IDLE cycle after REDIRECT.

## Test plan
- Basic: `pc_ex`=0x00000100 trigger; D$ done on its 3rd cycle, I$ done on its 1st. Expected: `dcache_flush` high cycles 1–3, `icache_clear` cycle 4, `redirect` cycle 5 with `redirect_pc`=0x00000104, `stall` high cycles 0–4.
- Wrap and skip: `SKIP_DCACHE`=1, `pc_ex`=0xFFFFFFFC, done immediate. Expected: `dcache_flush` never asserts, `redirect_pc`=0x00000000, `redirect` in cycle 2.
- Timeout: `TIMEOUT`=4, D$ done never asserted. Expected: DFLUSH for cycles 1–4, `icache_clear` never asserts, `redirect` and `fence_fault` in cycle 5, `fence_err`=1 thereafter.
- Tie: `TIMEOUT`=4, D$ done in the 4th DFLUSH cycle. Expected: ICLEAR follows, `fence_fault`=0.
- Spurious/gated inputs:
  - Done pulses in IDLE: no state change.
  - `ifence`=1 with `ex_valid`=0: no `stall` and no sequence.
  - `ifence` held during ICLEAR: ignored.
- Reset mid-op: `nRST`=0 during ICLEAR. Expected: at that edge all outputs reach reset values, no `redirect`, `fence_err` cleared.
